// File: rtl/cache_controller.sv
// MEM-stage data cache sequencer: write-hit updates, dirty-victim writeback, line refill,
// pipeline stall generation and a saturating miss counter.
module cache_controller #(
    parameter int MEM_LATENCY = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             cache_hit,
    input  logic             cache_dirty,
    output logic             stall,
    output logic             we_cache,
    output logic             cache_input_type,
    output logic             set_dirty,
    output logic             set_valid,
    output logic             memory_address_type,
    output logic             mem_we,
    output logic [CNT_W-1:0] miss_count,
    output logic [1:0]       dbg_state
);

    localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(MEM_LATENCY - 1);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WRITEBACK = 2'd1;
    localparam logic [1:0] ST_REFILL    = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] miss_count_q, miss_count_d;
    logic             req;
    logic             last_beat;

    assign req       = mem_read | mem_write;
    assign last_beat = (cnt_q == LAST_CNT);

    always_comb begin
        state_d             = state_q;
        cnt_d               = cnt_q;
        miss_count_d        = miss_count_q;
        stall               = 1'b0;
        we_cache            = 1'b0;
        cache_input_type    = 1'b0;
        set_dirty           = 1'b0;
        set_valid           = 1'b0;
        memory_address_type = 1'b0;
        mem_we              = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req && cache_hit) begin
                    // A simultaneous read+write is a store.
                    if (mem_write) begin
                        we_cache         = 1'b1;
                        cache_input_type = 1'b1;
                        set_dirty        = 1'b1;
                        set_valid        = 1'b1;
                    end
                end else if (req) begin
                    stall = 1'b1;
                    cnt_d = '0;
                    if (miss_count_q != {CNT_W{1'b1}}) begin
                        miss_count_d = miss_count_q + CNT_W'(1);
                    end
                    state_d = cache_dirty ? ST_WRITEBACK : ST_REFILL;
                end
            end

            ST_WRITEBACK: begin
                stall               = 1'b1;
                memory_address_type = 1'b1;
                mem_we              = 1'b1;
                if (last_beat) begin
                    cnt_d   = '0;
                    state_d = ST_REFILL;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            ST_REFILL: begin
                stall = 1'b1;
                if (last_beat) begin
                    // Line arrives on the final beat; the request retries as a hit next cycle.
                    we_cache  = 1'b1;
                    set_valid = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            miss_count_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign miss_count = miss_count_q;
    assign dbg_state  = state_q;

endmodule

// File: doc/cache_controller.md
Name: cache_controller

Overview:
- Sequencing FSM for the MEM-stage data cache.
- Takes mem_read/mem_write from the pipeline and hit/dirty status from the cache.
- Drives the cache/MEM-stage control inputs: we_cache, cache_input_type, set_dirty, set_valid, memory_address_type.
- Drives main-memory write enable and a pipeline stall during writeback and refill.
- Keeps a saturating miss counter for performance monitoring.

Parameters:
- MEM_LATENCY, 4, cycles per main-memory word access (writeback or refill); legal range ≥1.
- CNT_W, 16, width of miss_count.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_b  input  1  synchronous active-low reset.
- mem_read  input  1  load request from MEM stage.
- mem_write  input  1  store request from MEM stage.
- cache_hit  input  1  tag match and valid for current ALU address.
- cache_dirty  input  1  victim line dirty.
- stall  output  1  freeze IF..MEM pipeline registers.
- we_cache  output  1  cache write enable.
- cache_input_type  output  1  0 = data from memory (refill), 1 = rt data (store).
- set_dirty  output  1  dirty bit value written with we_cache.
- set_valid  output  1  valid bit value written with we_cache.
- memory_address_type  output  1  1 = victim writeback address, 0 = ALU address.
- mem_we  output  1  main-memory write enable.
- miss_count  output  CNT_W  number of misses since reset.

Behaviour:
- Reset: rst_b sampled low at a clk edge forces state to IDLE, the latency counter to 0 and miss_count to 0.
  - Reset overrides any in-progress writeback or refill; there is no partial-line recovery.
- Outputs in IDLE with no request are all 0.
- Outputs are combinational from state, counter and inputs; state, counter and miss_count are registered.
- req = mem_read | mem_write. Both asserted is treated as a write.
- IDLE:
  - No req: all outputs 0; stay.
  - req and hit, read: stall=0, no writes; completes in the same cycle (0 added latency).
  - req and hit, write: we_cache=1, cache_input_type=1, set_dirty=1, set_valid=1, stall=0; stay.
  - req and miss: stall=1, miss_count+1 (saturating at all-ones), counter←0.
    - cache_dirty=1 → WRITEBACK.
    - cache_dirty=0 → REFILL.
- WRITEBACK:
  - stall=1, memory_address_type=1, mem_we=1; counter increments each cycle.
  - At counter==MEM_LATENCY-1: counter←0, next state REFILL.
  - Occupies exactly MEM_LATENCY cycles.
- REFILL:
  - stall=1, memory_address_type=0, mem_we=0; counter increments each cycle.
  - In the cycle where counter==MEM_LATENCY-1: we_cache=1, cache_input_type=0, set_valid=1, set_dirty=0; next state IDLE.
  - Occupies exactly MEM_LATENCY cycles.
- After REFILL the request is re-evaluated in IDLE as a hit:
  - A load completes with stall=0.
  - A store performs the write-hit update with stall=0.
- Request dropped mid-WRITEBACK/REFILL: the sequence still runs to completion, then returns to IDLE. No abort.
- Hit/dirty inputs are ignored outside IDLE.
- Counter never exceeds MEM_LATENCY-1.
- miss_count holds at 2^CNT_W-1 once reached.
- Total stall cycles per miss: clean miss = 1+MEM_LATENCY; dirty miss = 1+2·MEM_LATENCY.

Test Plan (MEM_LATENCY=4):
1. Reset, then mem_read=1, cache_hit=1 → stall=0 same cycle; we_cache=0, mem_we=0; miss_count=0.
2. mem_write=1, cache_hit=1 → one cycle with we_cache=1, cache_input_type=1, set_dirty=1, set_valid=1, stall=0.
3. Clean read miss (hit=0, dirty=0) held until stall drops, cache model sets hit after refill:
   - stall high 5 cycles.
   - we_cache=1, cache_input_type=0, set_valid=1 only in the 5th stalled cycle.
   - mem_we never 1; miss_count=1.
4. Dirty write miss:
   - mem_we=1 with memory_address_type=1 for cycles 2–5.
   - Refill writes in cycle 9; stall high 9 cycles.
   - Cycle 10: store hit with set_dirty=1, stall=0; miss_count=1.
5. rst_b=0 during the 2nd WRITEBACK cycle → next cycle mem_we=0, stall=0 (no req), miss_count=0; state IDLE.
6. Read miss, then mem_read dropped in REFILL cycle 2 → refill completes (we_cache pulse in cycle 5), then all outputs 0.
   - With CNT_W=2, 5 consecutive misses → miss_count saturates at 3.
